// File: rtl/ahb_apb_bridge_mslv.sv
// AHB-Lite slave to multi-peripheral APB master bridge with wait states,
// slave-error and pready-timeout mapping onto a two-cycle AHB ERROR response.
module ahb_apb_bridge_mslv #(
  parameter int                ADDR_W      = 32,
  parameter int                DATA_W      = 32,
  parameter int                NUM_SLV     = 3,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = 'h8000_0000,
  parameter int                REGION_LOG2 = 26,
  parameter int                TIMEOUT     = 16
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              hwrite,
  input  logic              hreadyin,
  input  logic [1:0]        htrans,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [DATA_W-1:0] hwdata,
  output logic              hreadyout,
  output logic [1:0]        hresp,
  output logic [DATA_W-1:0] hrdata,
  output logic [NUM_SLV-1:0] psel,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  localparam int IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [ADDR_W+4:0] SPAN    = (ADDR_W + 5)'(NUM_SLV) << REGION_LOG2;
  localparam logic [CNT_W-1:0]  TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic [1:0] RESP_ERR  = 2'b01;

  typedef enum logic [2:0] {IDLE, WLATCH, SETUP, ACCESS, ERR1, ERR2} state_t;

  state_t             state, next;
  logic               accept, in_range, timed_out;
  logic [ADDR_W-1:0]  offset;
  logic [IDX_W-1:0]   dec_idx, idx;
  logic [CNT_W-1:0]   cnt;

  function automatic logic [NUM_SLV-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot    = '0;
    onehot[i] = 1'b1;
  endfunction

  assign accept    = hreadyout && hreadyin && (htrans == 2'b10 || htrans == 2'b11);
  assign offset    = haddr - BASE_ADDR;
  assign in_range  = (haddr >= BASE_ADDR) && ({5'b0, offset} < SPAN);
  assign dec_idx   = IDX_W'(offset >> REGION_LOG2);
  assign timed_out = (TIMEOUT != 0) && !pready && (cnt == TO_LAST);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) state <= IDLE;
    else        state <= next;
  end

  always_comb begin
    next = state;
    case (state)
      IDLE, ERR2: begin
        if (accept) next = !in_range ? ERR1 : (hwrite ? WLATCH : SETUP);
        else        next = IDLE;
      end
      WLATCH: next = SETUP;
      SETUP:  next = ACCESS;
      ACCESS: begin
        if (pready)         next = pslverr ? ERR1 : IDLE;
        else if (timed_out) next = ERR1;
      end
      ERR1:    next = ERR2;
      default: next = IDLE;
    endcase
  end

  // Registered bus outputs, updated on the same edge as the state change
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      hreadyout <= 1'b1;
      hresp     <= RESP_OKAY;
      hrdata    <= '0;
      psel      <= '0;
      penable   <= 1'b0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pwdata    <= '0;
      idx       <= '0;
    end else begin
      case (state)
        IDLE, ERR2: begin
          hresp <= RESP_OKAY;
          if (accept) begin
            hreadyout <= 1'b0;
            if (!in_range) begin
              hresp  <= RESP_ERR;
              hrdata <= '0;
            end else begin
              paddr  <= haddr;
              pwrite <= hwrite;
              idx    <= dec_idx;
              if (!hwrite) psel <= onehot(dec_idx);
            end
          end
        end
        WLATCH: begin
          pwdata <= hwdata;
          psel   <= onehot(idx);
        end
        SETUP: penable <= 1'b1;
        ACCESS: begin
          if (pready || timed_out) begin
            psel    <= '0;
            penable <= 1'b0;
          end
          if (pready && !pslverr) begin
            hreadyout <= 1'b1;
            hresp     <= RESP_OKAY;
            if (!pwrite) hrdata <= prdata;
          end else if (pready || timed_out) begin
            hresp  <= RESP_ERR;
            hrdata <= '0;
          end
        end
        ERR1: hreadyout <= 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset)                       cnt <= '0;
    else if (state != ACCESS)         cnt <= '0;
    else if (!pready)                 cnt <= cnt + 1'b1;
  end

endmodule

// File: tb/tb_ahb_apb_bridge_mslv.sv
// Directed bench for ahb_apb_bridge_mslv: a transfer table plus reset/BUSY sequences.
module tb_ahb_apb_bridge_mslv;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hwrite;
  logic        hreadyin;
  logic [1:0]  htrans;
  logic [31:0] haddr;
  logic [31:0] hwdata;
  logic        hreadyout;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [2:0]  psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  ahb_apb_bridge_mslv dut (
    .hclk(hclk), .hreset(hreset), .hwrite(hwrite), .hreadyin(hreadyin),
    .htrans(htrans), .haddr(haddr), .hwdata(hwdata), .hreadyout(hreadyout),
    .hresp(hresp), .hrdata(hrdata), .psel(psel), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .pready(pready), .pslverr(pslverr)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          waits;
    logic        err;
    logic [2:0]  exp_psel;
    int          exp_pen;
    int          exp_low;
    logic [1:0]  exp_resp;
    logic [31:0] exp_hrdata;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic do_xfer(input int n, input vec_t v);
    int          low = 0;
    int          pen = 0;
    logic [2:0]  psel_seen = '0;
    logic        psel_bad = 1'b0;
    logic [1:0]  lresp = 2'b00;
    logic [31:0] paddr_s = '0;
    logic        pwrite_s = 1'b0;
    logic [31:0] pwdata_s = '0;
    @(negedge hclk);
    htrans = 2'b10; haddr = v.addr; hwrite = v.wr; hreadyin = 1'b1;
    pready = 1'b0; pslverr = 1'b0;
    @(posedge hclk); #1;
    htrans = 2'b00; hwdata = v.wdata; prdata = v.rdata;
    for (int c = 0; c < 60 && !hreadyout; c++) begin
      low++;
      lresp = hresp;
      psel_seen |= psel;
      if (psel != 3'b000 && psel != v.exp_psel) psel_bad = 1'b1;
      if (psel != 3'b000 && !penable) begin
        paddr_s = paddr; pwrite_s = pwrite; pwdata_s = pwdata;
      end
      if (penable) begin
        pen++;
        pready  = (pen > v.waits);
        pslverr = pready & v.err;
      end else begin
        pready = 1'b0; pslverr = 1'b0;
      end
      @(posedge hclk); #1;
    end
    chk($sformatf("v%0d_complete", n), {31'b0, hreadyout}, 32'd1);
    chk($sformatf("v%0d_low_cycles", n), low, v.exp_low);
    chk($sformatf("v%0d_penable_cycles", n), pen, v.exp_pen);
    chk($sformatf("v%0d_psel", n), {29'b0, psel_seen}, {29'b0, v.exp_psel});
    chk($sformatf("v%0d_psel_stable", n), {31'b0, psel_bad}, 32'd0);
    chk($sformatf("v%0d_psel_end", n), {29'b0, psel}, 32'd0);
    chk($sformatf("v%0d_last_low_hresp", n), {30'b0, lresp}, {30'b0, v.exp_resp});
    chk($sformatf("v%0d_hresp", n), {30'b0, hresp}, {30'b0, v.exp_resp});
    chk($sformatf("v%0d_hrdata", n), hrdata, v.exp_hrdata);
    chk($sformatf("v%0d_paddr", n), paddr_s, (v.exp_psel != 3'b000) ? v.addr : 32'h0);
    chk($sformatf("v%0d_pwrite", n), {31'b0, pwrite_s},
        {31'b0, (v.exp_psel != 3'b000) ? v.wr : 1'b0});
    if (v.wr && v.exp_psel != 3'b000)
      chk($sformatf("v%0d_pwdata", n), pwdata_s, v.wdata);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t v;
    //            wr    addr          wdata         rdata         wt  err psel    pen low resp   hrdata
    tbl[0] = '{1'b0, 32'h8000_0010, 32'h0,        32'hDEAD_BEEF, 0, 1'b0, 3'b001, 1,  2, 2'b00, 32'hDEAD_BEEF};
    tbl[1] = '{1'b1, 32'h8400_0004, 32'h1234_5678, 32'hFFFF_FFFF, 0, 1'b0, 3'b010, 1,  3, 2'b00, 32'hDEAD_BEEF};
    tbl[2] = '{1'b0, 32'h8800_0000, 32'h0,        32'hCAFE_0001, 3, 1'b0, 3'b100, 4,  5, 2'b00, 32'hCAFE_0001};
    tbl[3] = '{1'b0, 32'h8C00_0000, 32'h0,        32'h7777_7777, 0, 1'b0, 3'b000, 0,  1, 2'b01, 32'h0};
    tbl[4] = '{1'b1, 32'h8000_0008, 32'hA5A5_A5A5, 32'hFFFF_FFFF, 0, 1'b1, 3'b001, 1,  4, 2'b01, 32'h0};
    tbl[5] = '{1'b0, 32'h8000_0000, 32'h0,        32'h1111_2222, 0, 1'b0, 3'b001, 1,  2, 2'b00, 32'h1111_2222};
    tbl[6] = '{1'b0, 32'h8400_0100, 32'h0,        32'h3333_3333, 99, 1'b0, 3'b010, 16, 18, 2'b01, 32'h0};
    tbl[7] = '{1'b0, 32'h8800_0040, 32'h0,        32'h55AA_55AA, 0, 1'b0, 3'b100, 1,  2, 2'b00, 32'h55AA_55AA};
    tbl[8] = '{1'b1, 32'h8BFF_FFFC, 32'h0BAD_F00D, 32'hFFFF_FFFF, 2, 1'b0, 3'b100, 3,  5, 2'b00, 32'h55AA_55AA};
    tbl[9] = '{1'b0, 32'h7FFF_FFFC, 32'h0,        32'h4444_4444, 0, 1'b0, 3'b000, 0,  1, 2'b01, 32'h0};

    hreset = 1'b1; hwrite = 1'b0; hreadyin = 1'b1; htrans = 2'b00;
    haddr = '0; hwdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    #1;
    chk("reset_hreadyout", {31'b0, hreadyout}, 32'd1);
    chk("reset_hresp", {30'b0, hresp}, 32'd0);
    chk("reset_hrdata", hrdata, 32'd0);
    chk("reset_psel", {29'b0, psel}, 32'd0);
    chk("reset_penable", {31'b0, penable}, 32'd0);
    chk("reset_paddr", paddr, 32'd0);
    chk("reset_pwdata", pwdata, 32'd0);
    repeat (2) @(negedge hclk);
    hreset = 1'b0;

    for (int i = 0; i < 10; i++) do_xfer(i, tbl[i]);

    // Reset asserted while the bridge waits in ACCESS
    @(negedge hclk);
    htrans = 2'b10; haddr = 32'h8000_0020; hwrite = 1'b0; pready = 1'b0;
    @(posedge hclk); #1;
    htrans = 2'b00;
    for (int c = 0; c < 10 && !penable; c++) begin
      @(posedge hclk); #1;
    end
    chk("rst_mid_in_access", {31'b0, penable}, 32'd1);
    #2 hreset = 1'b1;
    #1;
    chk("rst_mid_psel", {29'b0, psel}, 32'd0);
    chk("rst_mid_penable", {31'b0, penable}, 32'd0);
    chk("rst_mid_hreadyout", {31'b0, hreadyout}, 32'd1);
    chk("rst_mid_hresp", {30'b0, hresp}, 32'd0);
    @(negedge hclk);
    hreset = 1'b0;

    // BUSY transfers, and a NONSEQ with hreadyin low, must be ignored
    htrans = 2'b01; haddr = 32'h8000_0000; hreadyin = 1'b1; pready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (c == 2) begin htrans = 2'b10; hreadyin = 1'b0; end
      @(posedge hclk); #1;
      chk($sformatf("busy%0d_psel", c), {29'b0, psel}, 32'd0);
      chk($sformatf("busy%0d_hreadyout", c), {31'b0, hreadyout}, 32'd1);
      chk($sformatf("busy%0d_hresp", c), {30'b0, hresp}, 32'd0);
    end
    htrans = 2'b00; hreadyin = 1'b1;

    v = '{1'b0, 32'h8400_0008, 32'h0, 32'h600D_CAFE, 1, 1'b0, 3'b010, 2, 3, 2'b00, 32'h600D_CAFE};
    do_xfer(10, v);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ahb_apb_bridge_mslv.md
Name: ahb_apb_bridge_mslv

Overview:
Parametrised AHB-Lite slave to APB master bridge. It serves a configurable number of APB peripherals and decodes a contiguous address window into one psel line per peripheral. Unlike the fixed three-slave bridge, it honours APB wait states (pready), maps pslverr, out-of-range addresses and a pready timeout onto a two-cycle AHB ERROR response, and uses a shorter path for reads. It sits between the AHB interconnect and the peripheral APB segment.

Parameters:
ADDR_W, 32, address width of haddr and paddr.
DATA_W, 32, data width of hwdata, hrdata, pwdata and prdata.
NUM_SLV, 3, number of APB slaves; also the psel width; range 1..16.
BASE_ADDR, 32'h8000_0000, base of the decoded window.
REGION_LOG2, 26, log2 of the byte size of each slave region.
TIMEOUT, 16, maximum ACCESS cycles with pready low; 0 disables the timeout.

Ports:
hclk  in  1  clock.
hreset  in  1  asynchronous, active-high reset.
hwrite  in  1  AHB transfer direction; 1 = write.
hreadyin  in  1  AHB bus ready.
htrans  in  2  AHB transfer type.
haddr  in  ADDR_W  AHB address.
hwdata  in  DATA_W  AHB write data, valid in the data phase.
hreadyout  out  1  bridge ready.
hresp  out  2  00 = OKAY, 01 = ERROR.
hrdata  out  DATA_W  read data.
psel  out  NUM_SLV  one-hot APB select.
penable  out  1  APB enable.
pwrite  out  1  APB direction.
paddr  out  ADDR_W  APB address.
pwdata  out  DATA_W  APB write data.
prdata  in  DATA_W  APB read data.
pready  in  1  APB ready.
pslverr  in  1  APB slave error.

Behaviour:
- All outputs are registered and reset asynchronously. Reset values: hreadyout=1, hresp=00, hrdata=0, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0; state=IDLE; timeout counter=0.
- Accept condition, sampled at a clock edge: hreadyout=1 and hreadyin=1 and htrans is 10 or 11. htrans 00 or 01 is ignored and the bridge keeps hresp=00.
- Decode: in range when BASE_ADDR <= haddr < BASE_ADDR + (NUM_SLV << REGION_LOG2). Slave index = (haddr - BASE_ADDR) >> REGION_LOG2.
- States:
  - IDLE, ERR2: a transfer may be accepted.
    - Out of range → ERR1.
    - In-range write → WLATCH.
    - In-range read → SETUP.
    - Otherwise → IDLE.
    - On accept, latch haddr, hwrite and slave index.
  - WLATCH: hreadyout=0; capture hwdata into pwdata; → SETUP.
  - SETUP: psel[idx]=1, penable=0, paddr and pwrite valid; hreadyout=0; → ACCESS.
  - ACCESS: penable=1; increment the timeout counter while pready=0.
    - pready=1, pslverr=0 → IDLE. At that edge: hreadyout←1, hresp←00, hrdata←prdata on reads (hrdata holds its value on writes), psel←0, penable←0.
    - pready=1, pslverr=1 → ERR1.
    - TIMEOUT≠0 and counter reaches TIMEOUT-1 with pready=0 → ERR1.
  - ERR1: hreadyout=0, hresp=01, psel=0, penable=0, hrdata=0; → ERR2.
  - ERR2: hreadyout=1, hresp=01; the counter clears; acceptance as in IDLE, otherwise → IDLE with hresp←00.
- Latency with zero wait states, counted from the address-sampling edge E0:
  - Read: SETUP E0–E1, ACCESS E1–E2, hreadyout high E2–E3 with hrdata valid.
  - Write: one extra cycle for WLATCH.
- Each pready-low cycle adds exactly one cycle to the transfer.
- Back-to-back transfers: the next address is accepted at the edge ending the hreadyout-high cycle. The bridge never has more than one outstanding APB transfer.
- Asserting reset mid-transfer drops psel and penable at once, with no APB completion and no AHB response.
- pready and pslverr are ignored outside ACCESS.

Test Plan:
- Reset, then read of 0x8000_0010 with prdata=0xDEADBEEF and pready=1 → psel=001 for one SETUP and one ACCESS cycle, paddr=0x8000_0010, hrdata=0xDEADBEEF, hreadyout low for exactly 2 cycles, hresp=00.
- Write to 0x8400_0004 with hwdata=0x1234_5678 → WLATCH, then psel=010 with pwrite=1 and pwdata=0x1234_5678; hreadyout low 3 cycles.
- Read from 0x8800_0000 with pready held low for 3 cycles → penable high 4 cycles, hreadyout low 5 cycles, psel stable at 100 throughout.
- Access to 0x8C00_0000 (NUM_SLV=3) → no psel activity; hreadyout 0 then 1 with hresp=01 on both cycles, hrdata=0.
- pready=1 with pslverr=1 on a write, and separately pready stuck low → the first gives ERR1/ERR2 immediately; the second gives ERR1 after 16 ACCESS cycles. Both drop psel and penable, then a following read completes OKAY.
- hreset asserted in ACCESS → psel=0, penable=0, hreadyout=1 in the same cycle; htrans=01 (BUSY) after reset → no APB activity.
